// File: rtl/parking_gate_arbiter_if.sv
// Lane-side bundle for parking_gate_arbiter: sensor/auth inputs, gate/grant/occupancy outputs,
// plus the arbiter's current state for observation.
interface parking_gate_arbiter_if #(
    parameter int CNT_W = 4
);
    logic             entry_req;
    logic             entry_auth;
    logic             exit_req;
    logic             pass_clear;
    logic             entry_grant;
    logic             exit_grant;
    logic             gate_open;
    logic             full;
    logic [CNT_W-1:0] occupancy;
    logic             timeout;
    logic [2:0]       state;

    // Handshake: requests are levels sampled on the rising edge; entry_auth and pass_clear are
    // single-cycle pulses honoured only in the state that consumes them, otherwise dropped.
    modport master (
        output entry_req, entry_auth, exit_req, pass_clear,
        input  entry_grant, exit_grant, gate_open, full, occupancy, timeout, state
    );

    modport slave (
        input  entry_req, entry_auth, exit_req, pass_clear,
        output entry_grant, exit_grant, gate_open, full, occupancy, timeout, state
    );
endinterface

// File: rtl/parking_gate_arbiter.sv
// Single-gate arbiter between entry and exit lanes with occupancy tracking.
// Define ROUND_ROBIN_EN to alternate simultaneous requests instead of fixed exit priority.
module parking_gate_arbiter #(
    parameter int CAPACITY    = 8,
    parameter int CNT_W       = 4,
    parameter int TIMEOUT_CYC = 64,
    parameter int SETTLE_CYC  = 4
) (
    input  logic                   clock_in,
    input  logic                   rst_in,
    parking_gate_arbiter_if.slave  bus
);
    localparam int TMR_W = $clog2(TIMEOUT_CYC) + 1;
    localparam logic [TMR_W-1:0] TMO_LAST    = TMR_W'(TIMEOUT_CYC - 1);
    localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] CAP         = CNT_W'(CAPACITY);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        AUTH       = 3'd1,
        ENTRY_OPEN = 3'd2,
        EXIT_OPEN  = 3'd3,
        SETTLE     = 3'd4
    } state_t;

    state_t           state, state_n;
    logic [TMR_W-1:0] timer, timer_n;
    logic [CNT_W-1:0] occupancy_q, occ_n;
    logic             full_q, timeout_q, to_n;
    logic             entry_grant_q, exit_grant_q, gate_open_q;
    logic             exit_ok, entry_ok, pick_exit;

    assign exit_ok  = bus.exit_req && (occupancy_q != '0);
    assign entry_ok = bus.entry_req && !full_q;

`ifdef ROUND_ROBIN_EN
    // Set when the exit lane received the most recent grant; reset value means entry went last.
    logic last_exit;

    assign pick_exit = exit_ok && (!entry_ok || !last_exit);

    always_ff @(posedge clock_in or negedge rst_in) begin
        if (!rst_in) begin
            last_exit <= 1'b0;
        end else if (state == IDLE && state_n == EXIT_OPEN) begin
            last_exit <= 1'b1;
        end else if (state == IDLE && state_n == AUTH) begin
            last_exit <= 1'b0;
        end
    end
`else
    assign pick_exit = exit_ok;
`endif

    always_comb begin
        state_n = state;
        occ_n   = occupancy_q;
        to_n    = 1'b0;
        case (state)
            IDLE: begin
                if (pick_exit) state_n = EXIT_OPEN;
                else if (entry_ok) state_n = AUTH;
            end
            AUTH: begin
                if (bus.entry_auth) begin
                    state_n = ENTRY_OPEN;
                end else if (!bus.entry_req) begin
                    state_n = SETTLE;
                end else if (timer == TMO_LAST) begin
                    state_n = SETTLE;
                    to_n    = 1'b1;
                end
            end
            ENTRY_OPEN: begin
                // A clear arriving on the expiry cycle still counts the vehicle.
                if (bus.pass_clear) begin
                    state_n = SETTLE;
                    if (occupancy_q != CAP) occ_n = occupancy_q + CNT_W'(1);
                end else if (timer == TMO_LAST) begin
                    state_n = SETTLE;
                    to_n    = 1'b1;
                end
            end
            EXIT_OPEN: begin
                if (bus.pass_clear) begin
                    state_n = SETTLE;
                    if (occupancy_q != '0) occ_n = occupancy_q - CNT_W'(1);
                end else if (timer == TMO_LAST) begin
                    state_n = SETTLE;
                    to_n    = 1'b1;
                end
            end
            SETTLE: begin
                if (timer == SETTLE_LAST) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
        timer_n = (state_n != state || state == IDLE) ? '0 : timer + TMR_W'(1);
    end

    always_ff @(posedge clock_in or negedge rst_in) begin
        if (!rst_in) begin
            state         <= IDLE;
            timer         <= '0;
            occupancy_q   <= '0;
            full_q        <= 1'b0;
            timeout_q     <= 1'b0;
            entry_grant_q <= 1'b0;
            exit_grant_q  <= 1'b0;
            gate_open_q   <= 1'b0;
        end else begin
            state         <= state_n;
            timer         <= timer_n;
            occupancy_q   <= occ_n;
            full_q        <= (occ_n == CAP);
            timeout_q     <= to_n;
            entry_grant_q <= (state_n == AUTH) || (state_n == ENTRY_OPEN);
            exit_grant_q  <= (state_n == EXIT_OPEN);
            gate_open_q   <= (state_n == ENTRY_OPEN) || (state_n == EXIT_OPEN);
        end
    end

    assign bus.entry_grant = entry_grant_q;
    assign bus.exit_grant  = exit_grant_q;
    assign bus.gate_open   = gate_open_q;
    assign bus.full        = full_q;
    assign bus.occupancy   = occupancy_q;
    assign bus.timeout     = timeout_q;
    assign bus.state       = state;
endmodule

// File: tb/tb_parking_gate_arbiter.sv
// Directed and randomized bench for parking_gate_arbiter against a lane-level behavioural model.
module tb_parking_gate_arbiter;
    localparam int CAPACITY    = 8;
    localparam int CNT_W       = 4;
    localparam int TIMEOUT_CYC = 64;
    localparam int SETTLE_CYC  = 4;

    logic clock_in;
    logic rst_in;
    int   n_cmp = 0;
    int   n_mis = 0;

    parking_gate_arbiter_if #(.CNT_W(CNT_W)) bus ();

    parking_gate_arbiter #(
        .CAPACITY(CAPACITY), .CNT_W(CNT_W), .TIMEOUT_CYC(TIMEOUT_CYC), .SETTLE_CYC(SETTLE_CYC)
    ) dut (
        .clock_in(clock_in),
        .rst_in(rst_in),
        .bus(bus)
    );

    initial begin
        clock_in = 1'b0;
        forever #5 clock_in = ~clock_in;
    end

    // Lane-level model: who holds the gate, whether the barrier is up, how long the
    // current phase has lasted, and how many closed-gate cycles remain.
    int m_owner;       // 0 nobody, 1 entry lane, 2 exit lane
    bit m_opened;
    int m_age;
    int m_settle_left;
    int m_occ;
    bit m_to;
    bit m_last_exit;

    task automatic model_reset();
        m_owner = 0; m_opened = 0; m_age = 0; m_settle_left = 0;
        m_occ = 0; m_to = 0; m_last_exit = 0;
    endtask

    task automatic model_release();
        m_owner = 0; m_opened = 0; m_age = 0; m_settle_left = SETTLE_CYC;
    endtask

    task automatic model_step(input bit er, input bit ea, input bit xr, input bit pc);
        bit can_exit, can_entry, go_exit;
        m_to = 0;
        if (m_settle_left > 0) begin
            m_settle_left--;
        end else if (m_owner == 0) begin
            can_exit  = xr && (m_occ > 0);
            can_entry = er && (m_occ < CAPACITY);
`ifdef ROUND_ROBIN_EN
            go_exit = can_exit && (!can_entry || !m_last_exit);
`else
            go_exit = can_exit;
`endif
            if (go_exit) begin
                m_owner = 2; m_opened = 1; m_age = 0; m_last_exit = 1;
            end else if (can_entry) begin
                m_owner = 1; m_opened = 0; m_age = 0; m_last_exit = 0;
            end
        end else if (!m_opened) begin
            if (ea) begin
                m_opened = 1; m_age = 0;
            end else if (!er) begin
                model_release();
            end else if (m_age == TIMEOUT_CYC - 1) begin
                model_release(); m_to = 1;
            end else begin
                m_age++;
            end
        end else begin
            if (pc) begin
                if (m_owner == 1 && m_occ < CAPACITY) m_occ++;
                if (m_owner == 2 && m_occ > 0) m_occ--;
                model_release();
            end else if (m_age == TIMEOUT_CYC - 1) begin
                model_release(); m_to = 1;
            end else begin
                m_age++;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("entry_grant", 32'(bus.entry_grant), 32'(m_owner == 1));
        chk("exit_grant",  32'(bus.exit_grant),  32'(m_owner == 2));
        chk("gate_open",   32'(bus.gate_open),   32'(m_opened));
        chk("full",        32'(bus.full),        32'(m_occ == CAPACITY));
        chk("occupancy",   32'(bus.occupancy),   32'(m_occ));
        chk("timeout",     32'(bus.timeout),     32'(m_to));
    endtask

    // Drive at the falling edge, let the model see the same inputs the DUT samples, check after the edge.
    task automatic cyc(input bit er, input bit ea, input bit xr, input bit pc);
        @(negedge clock_in);
        bus.entry_req = er; bus.entry_auth = ea; bus.exit_req = xr; bus.pass_clear = pc;
        @(posedge clock_in);
        model_step(er, ea, xr, pc);
        #1;
        check_all();
    endtask

    // Lanes behave cooperatively: authorise as soon as entry is granted, clear as soon as the gate is up.
    task automatic auto_cyc(input bit er, input bit xr);
        cyc(er, (m_owner == 1 && !m_opened), xr, m_opened);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 100 && (m_owner != 0 || m_settle_left != 0); i++) auto_cyc(0, 0);
        chk("reached_idle", 32'(m_owner == 0 && m_settle_left == 0), 32'd1);
    endtask

    int tmo_seen;
    int open_seen;

    initial begin
        rst_in = 1'b0;
        bus.entry_req = 0; bus.entry_auth = 0; bus.exit_req = 0; bus.pass_clear = 0;
        model_reset();
        repeat (3) @(posedge clock_in);
        #1;
        check_all();
        @(negedge clock_in);
        rst_in = 1'b1;

        // Single entry: auth on cycle 5, clear on cycle 12.
        for (int c = 0; c < 18; c++) cyc(c <= 12, c == 5, 0, c == 12);
        chk("t1_occ", 32'(bus.occupancy), 32'd1);

        // Fill the lot, then a refused ninth vehicle.
        for (int i = 0; i < 200 && m_occ < CAPACITY; i++) auto_cyc(1, 0);
        wait_idle();
        open_seen = 0;
        for (int i = 0; i < 12; i++) begin
            cyc(1, 1, 0, 1);
            if (bus.gate_open || bus.entry_grant) open_seen++;
        end
        chk("t2_refused", 32'(open_seen), 32'd0);
        chk("t2_full", 32'(bus.full), 32'd1);
        chk("t2_occ", 32'(bus.occupancy), 32'd8);

        // Drain to 3, then simultaneous requests.
        for (int i = 0; i < 200 && m_occ > 3; i++) auto_cyc(0, 1);
        wait_idle();
        auto_cyc(1, 1);
        for (int i = 0; i < 14; i++) auto_cyc(1, 0);
        wait_idle();
        for (int i = 0; i < 30; i++) auto_cyc(1, 1);
        wait_idle();

        // Entry held without authorisation until it times out.
        tmo_seen = 0; open_seen = 0;
        for (int i = 0; i < 70; i++) begin
            cyc(1, 0, 0, 0);
            if (bus.timeout) tmo_seen++;
            if (bus.gate_open) open_seen++;
        end
        chk("t4_timeouts", 32'(tmo_seen), 32'd1);
        chk("t4_gate", 32'(open_seen), 32'd0);
        for (int i = 0; i < 100 && (m_owner != 0 || m_settle_left != 0); i++) cyc(0, 0, 0, 0);

        // Asynchronous reset while the exit gate is open at occupancy 5.
        for (int i = 0; i < 300 && m_occ < 5; i++) auto_cyc(1, 0);
        for (int i = 0; i < 300 && m_occ > 5; i++) auto_cyc(0, 1);
        wait_idle();
        cyc(0, 0, 1, 0);
        chk("t5_exit_open", 32'(bus.exit_grant && bus.gate_open), 32'd1);
        chk("t5_occ_before", 32'(bus.occupancy), 32'd5);
        #2;
        rst_in = 1'b0;
        #1;
        chk("t5_gate", 32'(bus.gate_open), 32'd0);
        chk("t5_exit_grant", 32'(bus.exit_grant), 32'd0);
        chk("t5_occ", 32'(bus.occupancy), 32'd0);
        model_reset();
        bus.exit_req = 0;
        @(negedge clock_in);
        rst_in = 1'b1;

        // Exit request and stray clear at empty lot.
        for (int i = 0; i < 4; i++) cyc(0, 0, 1, 0);
        cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 0);
        chk("t6_occ", 32'(bus.occupancy), 32'd0);
        chk("t6_exit_grant", 32'(bus.exit_grant), 32'd0);

        // Random lane activity.
        for (int i = 0; i < 3000; i++) begin
            cyc($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0,
                $urandom_range(0, 2) == 0, $urandom_range(0, 5) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
